// File: rtl/xpb_table_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_table_gen_if
//  Purpose  : Request/write bundle between a requester, the XPB table
//             generator and the table RAM write port.
//  Signals  : start/shift/modulus  - job request (requester -> generator)
//             busy/done/err        - job status  (generator -> requester)
//             wr_en/wr_addr/wr_data- table write port (generator -> RAM)
//  Modports : master - requester side, slave - generator side
//  Revision : 1.0  initial release
// ============================================================================
interface xpb_table_gen_if #(
    parameter int MOD_LEN  = 1024,
    parameter int SEG_BITS = 5,
    parameter int SHIFT_W  = 11
);
    logic                start;
    logic [SHIFT_W-1:0]  shift;
    logic [MOD_LEN-1:0]  modulus;
    logic                busy;
    logic                done;
    logic                err;
    logic                wr_en;
    logic [SEG_BITS-1:0] wr_addr;
    logic [MOD_LEN-1:0]  wr_data;

    modport master (
        output start, shift, modulus,
        input  busy, done, err, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, shift, modulus,
        output busy, done, err, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/xpb_table_gen.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_table_gen
//  Purpose  : Builds the XPB reduction table entry[j] = (j * 2^K) mod N for
//             j = 0 .. 2^SEG_BITS-1 and streams it into the table RAM.
//             First 2^K mod N is formed by K modular doublings, then the
//             entries are produced by repeated modular addition of that base.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous active-high reset
//             bus    - xpb_table_gen_if.slave: start/shift/modulus request,
//                      busy/done/err status, wr_en/wr_addr/wr_data writes
//  Revision : 1.0  initial release
// ============================================================================
module xpb_table_gen #(
    parameter int MOD_LEN  = 1024,
    parameter int SEG_BITS = 5,
    parameter int SHIFT_W  = 11
) (
    input  logic            clk,
    input  logic            reset,
    xpb_table_gen_if.slave  bus
);

    localparam logic [SEG_BITS-1:0] C_LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DBL  = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t              r_state;
    logic [MOD_LEN-1:0]  r_n;      // latched modulus
    logic [SHIFT_W-1:0]  r_cnt;    // remaining doublings (latched K)
    logic [MOD_LEN-1:0]  r_x;      // running 2^i mod N
    logic [MOD_LEN-1:0]  r_base;   // 2^K mod N
    logic [MOD_LEN-1:0]  r_acc;    // current entry, drives wr_data
    logic [SEG_BITS-1:0] r_wr_addr;
    logic                r_wr_en;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    // Both operands stay below N, so a single conditional subtract at
    // MOD_LEN+1 bits fully reduces the doubled value and the sum.
    logic [MOD_LEN:0]    w_n_ext;
    logic [MOD_LEN:0]    w_dbl;
    logic [MOD_LEN:0]    w_dbl_red;
    logic [MOD_LEN:0]    w_sum;
    logic [MOD_LEN:0]    w_sum_red;
    logic [MOD_LEN-1:0]  w_x_next;
    logic [MOD_LEN-1:0]  w_acc_next;
    logic                w_bad_mod;

    assign w_n_ext    = {1'b0, r_n};
    assign w_dbl      = {r_x, 1'b0};
    assign w_dbl_red  = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_base};
    assign w_sum_red  = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
    // The reduced results are < N, so their top bit is always zero.
    assign w_x_next   = MOD_LEN'(w_dbl_red);
    assign w_acc_next = MOD_LEN'(w_sum_red);
    assign w_bad_mod  = (bus.modulus <= MOD_LEN'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_n       <= '0;
            r_cnt     <= '0;
            r_x       <= '0;
            r_base    <= '0;
            r_acc     <= '0;
            r_wr_addr <= '0;
            r_wr_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_n   <= bus.modulus;
                        r_cnt <= bus.shift;
                        r_x   <= MOD_LEN'(1);
                        if (w_bad_mod) begin
                            // Degenerate modulus: report straight away, no writes.
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_err  <= 1'b0;
                            r_busy <= 1'b1;
                            if (bus.shift != '0) begin
                                r_state <= ST_DBL;
                            end else begin
                                // 2^0 mod N = 1 since N >= 2
                                r_base    <= MOD_LEN'(1);
                                r_acc     <= '0;
                                r_wr_addr <= '0;
                                r_wr_en   <= 1'b1;
                                r_state   <= ST_WR;
                            end
                        end
                    end
                end

                ST_DBL: begin
                    r_x   <= w_x_next;
                    r_cnt <= r_cnt - SHIFT_W'(1);
                    if (r_cnt == SHIFT_W'(1)) begin
                        // Final doubling feeds the base directly so the first
                        // write lands in the very next cycle.
                        r_base    <= w_x_next;
                        r_acc     <= '0;
                        r_wr_addr <= '0;
                        r_wr_en   <= 1'b1;
                        r_state   <= ST_WR;
                    end
                end

                ST_WR: begin
                    if (r_wr_addr == C_LAST_ADDR) begin
                        // Address and data hold their last written values.
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_acc     <= w_acc_next;
                        r_wr_addr <= r_wr_addr + SEG_BITS'(1);
                    end
                end

                ST_FIN: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_acc;

endmodule
`default_nettype wire

// File: doc/xpb_table_gen.md
Name: xpb_table_gen

Overview:
- Sequential generator for the XPB reduction tables used by the modular squaring datapath.
- For modulus N and bit position K, computes entry[j] = (j · 2^K) mod N for j = 0 … 2^SEG_BITS−1.
- Writes the entries in order through a simple write port into the table RAM that the reduction lookup reads.
- Lets tables be rebuilt at runtime for a new modulus instead of being fixed constants.

Parameters:
- MOD_LEN, 1024, modulus and table entry width in bits.
- SEG_BITS, 5, lookup segment width; the table has 2^SEG_BITS entries.
- SHIFT_W, 11, width of the bit-position input K.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- shift  input  SHIFT_W  bit position K; latched on an accepted start.
- modulus  input  MOD_LEN  modulus N; latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start through the last write cycle.
- done  output  1  one-cycle pulse at the end of every accepted job, including error jobs.
- err  output  1  set with done when N ≤ 1; held until the next accepted start.
- wr_en  output  1  table write strobe.
- wr_addr  output  SEG_BITS  table entry index j.
- wr_data  output  MOD_LEN  entry value, always < N.

Behaviour:
- Reset: state IDLE. busy, done, err, wr_en = 0. wr_addr = 0. wr_data = 0. Internal registers cleared.
- Reset mid-job aborts immediately: no further writes. Partially written table contents are undefined and the caller must restart.
- States: IDLE, DBL, WR, FIN.
- IDLE: on start=1:
  - latch N and K; clear err.
  - if N ≤ 1: go to FIN with err set.
  - else: x ← 1, cnt ← K; go to DBL if K ≠ 0, else go to WR.
- DBL: one doubling per cycle, x ← 2x mod N, cnt ← cnt−1.
  - 2x is formed at MOD_LEN+1 bits; subtract N once if 2x ≥ N. This is valid because the invariant x < N holds.
  - When cnt reaches 1, the last doubling completes and the state moves to WR.
  - DBL lasts exactly K cycles.
- WR: entry 0 setup: base ← x, acc ← 0, j ← 0.
  - Each WR cycle: wr_en=1, wr_addr=j, wr_data=acc.
  - Next cycle: acc ← acc+base mod N, using one conditional subtract at MOD_LEN+1 bits; j ← j+1.
  - Lasts exactly 2^SEG_BITS cycles; addresses run 0 to 2^SEG_BITS−1 consecutively with no gaps.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Timing: if start is accepted in cycle 0:
  - first write occurs at cycle K+1;
  - last write at cycle K+2^SEG_BITS;
  - done at cycle K+2^SEG_BITS+1.
  - Error job: done at cycle 1, with no writes.
- start while not in IDLE, including during FIN, is ignored. There is no queueing.
- modulus and shift inputs may change freely after acceptance; only the latched copies are used.
- wr_data and wr_addr are don't-care when wr_en=0 but must hold their last value; no X is permitted.
- N need not be odd. Any N ≥ 2 is legal. Entries wrap modulo N, so repeated values are legal.
- K may be any value up to 2^SHIFT_W−1. No upper bound is imposed relative to MOD_LEN.

Test Plan:
- MOD_LEN=16, SEG_BITS=3, N=13, K=4 → base 3. Writes addr0–7 = 0,3,6,9,12,2,5,8. done exactly 13 cycles after start.
- MOD_LEN=16, SEG_BITS=3, N=5, K=0 → no DBL cycles. Writes 0,1,2,3,4,0,1,2 at cycles 1–8. done at cycle 9.
- Default parameters, random 1024-bit N with the top bit set, K=795 → all 32 entries match a software big-integer model of (j·2^795) mod N. done at cycle 828.
- N=1 (and N=0), K=7 → wr_en never asserted. done and err high at cycle 1. err cleared by the next valid start.
- start pulsed again at cycle 3 of a job with N=13, K=4 → ignored. Exactly 8 writes, exactly one done pulse.
- reset asserted during the 4th WR cycle → next cycle wr_en=0, busy=0, done=0. A following fresh start produces the full correct table.
